// File: rtl/obi_apb_splitter_pkg.sv
// obi_apb_splitter_pkg: shared FSM type, control bit positions and window decode helper
package obi_apb_splitter_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
  localparam int IDX_W = 4;
  localparam int CTRL_TMO_EN = 0;
  localparam int CTRL_UNMAP_ERR = 1;
  typedef struct packed {
    logic hit;
    logic [IDX_W-1:0] idx;
  } dec_t;
  function automatic dec_t decode_addr(input logic [63:0] addr, input logic [63:0] base, input int size_lg, input int num);
    dec_t d;
    logic [63:0] slot;
    slot = (addr - base) >> size_lg;
    d.hit = addr >= base && slot < 64'(num);
    d.idx = slot[IDX_W-1:0];
    return d;
  endfunction
endpackage

// File: rtl/obi_apb_splitter_decode.sv
// obi_apb_splitter_decode: maps a byte address onto one of NUM_TARGETS equal windows
module obi_apb_splitter_decode
  import obi_apb_splitter_pkg::*;
#(
  parameter int OBI_AW = 32,
  parameter logic [OBI_AW-1:0] ADDR_BASE = 32'h0105_0000,
  parameter int unsigned SS_SIZE = 32'h1000,
  parameter int NUM_TARGETS = 5
) (
  input  logic [OBI_AW-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);
  dec_t d;
  assign d = decode_addr(64'(addr), 64'(ADDR_BASE), $clog2(SS_SIZE), NUM_TARGETS);
  assign hit = d.hit;
  assign idx = d.idx;
endmodule

// File: rtl/obi_apb_splitter.sv
// obi_apb_splitter: single-initiator OBI to NUM_TARGETS-port APB4 splitter with unmapped error and timeout abort
module obi_apb_splitter
  import obi_apb_splitter_pkg::*;
#(
  parameter int NUM_TARGETS = 5,
  parameter int OBI_AW = 32,
  parameter int OBI_DW = 32,
  parameter int OBI_IDW = 1,
  parameter int APB_AW = 32,
  parameter logic [OBI_AW-1:0] ADDR_BASE = 32'h0105_0000,
  parameter int unsigned SS_SIZE = 32'h1000,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int SS_CTRL_W = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          obi_req,
  input  logic                          obi_reqpar,
  output logic                          obi_gnt,
  output logic                          obi_gntpar,
  input  logic [OBI_AW-1:0]             obi_addr,
  input  logic                          obi_we,
  input  logic [OBI_DW/8-1:0]           obi_be,
  input  logic [OBI_DW-1:0]             obi_wdata,
  input  logic [OBI_IDW-1:0]            obi_aid,
  output logic                          obi_rvalid,
  output logic                          obi_rvalidpar,
  input  logic                          obi_rready,
  input  logic                          obi_rreadypar,
  output logic [OBI_DW-1:0]             obi_rdata,
  output logic                          obi_err,
  output logic [OBI_IDW-1:0]            obi_rid,
  output logic [APB_AW-1:0]             apb_paddr,
  output logic [OBI_DW-1:0]             apb_pwdata,
  output logic                          apb_pwrite,
  output logic [OBI_DW/8-1:0]           apb_pstrb,
  output logic                          apb_penable,
  output logic [NUM_TARGETS-1:0]        apb_psel,
  input  logic [NUM_TARGETS*OBI_DW-1:0] apb_prdata,
  input  logic [NUM_TARGETS-1:0]        apb_pready,
  input  logic [NUM_TARGETS-1:0]        apb_pslverr,
  input  logic [SS_CTRL_W-1:0]          ss_ctrl_icn
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  state_e state_q, state_d;
  logic hit;
  logic [IDX_W-1:0] idx, idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_TARGETS-1:0] onehot;
  logic sel_ready, sel_err, err_d, pwrite_d;
  logic [OBI_DW-1:0] sel_rdata, rdata_d, pwdata_d;
  logic [OBI_IDW-1:0] rid_d;
  logic [APB_AW-1:0] paddr_d;
  logic [OBI_DW/8-1:0] pstrb_d;
  logic unused_ok;
  obi_apb_splitter_decode #(
    .OBI_AW(OBI_AW),
    .ADDR_BASE(ADDR_BASE),
    .SS_SIZE(SS_SIZE),
    .NUM_TARGETS(NUM_TARGETS)
  ) u_decode (
    .addr(obi_addr),
    .hit(hit),
    .idx(idx)
  );
  assign obi_gnt = state_q == IDLE && obi_req && !reset;
  assign obi_gntpar = ~obi_gnt;
  assign obi_rvalid = state_q == RESP;
  assign obi_rvalidpar = ~obi_rvalid;
  assign apb_psel = (state_q == SETUP || state_q == ACCESS) ? onehot : '0;
  assign apb_penable = state_q == ACCESS;
  assign unused_ok = ^{obi_reqpar, obi_rreadypar, ss_ctrl_icn};
  always_comb begin
    onehot = '0;
    sel_ready = 1'b0;
    sel_err = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_TARGETS; i++)
      if (idx_q == IDX_W'(i)) begin
        onehot[i] = 1'b1;
        sel_ready = apb_pready[i];
        sel_err = apb_pslverr[i];
        sel_rdata = apb_prdata[i*OBI_DW +: OBI_DW];
      end
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    rdata_d = obi_rdata;
    err_d = obi_err;
    rid_d = obi_rid;
    paddr_d = apb_paddr;
    pwdata_d = apb_pwdata;
    pwrite_d = apb_pwrite;
    pstrb_d = apb_pstrb;
    case (state_q)
      IDLE:
        if (obi_gnt) begin
          rid_d = obi_aid;
          idx_d = idx;
          if (hit) begin
            state_d = SETUP;
            paddr_d = obi_addr[APB_AW-1:0];
            pwdata_d = obi_wdata;
            pwrite_d = obi_we;
            pstrb_d = obi_we ? obi_be : '0;
          end else begin
            state_d = RESP;
            rdata_d = '0;
            err_d = ss_ctrl_icn[CTRL_UNMAP_ERR];
          end
        end
      SETUP: begin
        state_d = ACCESS;
        cnt_d = '0;
      end
      ACCESS:
        if (sel_ready) begin
          state_d = RESP;
          rdata_d = apb_pwrite ? '0 : sel_rdata;
          err_d = sel_err;
        end else if (ss_ctrl_icn[CTRL_TMO_EN] && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = RESP;
          rdata_d = '0;
          err_d = 1'b1;
        end else
          cnt_d = cnt_q == CW'(TIMEOUT_CYCLES - 1) ? cnt_q : cnt_q + CW'(1);
      default: state_d = obi_rready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      obi_rdata <= '0;
      obi_err <= 1'b0;
      obi_rid <= '0;
      apb_paddr <= '0;
      apb_pwdata <= '0;
      apb_pwrite <= 1'b0;
      apb_pstrb <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      obi_rdata <= rdata_d;
      obi_err <= err_d;
      obi_rid <= rid_d;
      apb_paddr <= paddr_d;
      apb_pwdata <= pwdata_d;
      apb_pwrite <= pwrite_d;
      apb_pstrb <= pstrb_d;
    end
endmodule

// File: tb/tb_obi_apb_splitter.sv
// tb_obi_apb_splitter: randomized scoreboard bench with a window-arithmetic reference model
module tb_obi_apb_splitter;
  localparam int N = 5;
  localparam int DW = 32;
  localparam int IDW = 1;
  localparam logic [31:0] BASE = 32'h0105_0000;
  localparam int SS = 32'h1000;
  localparam int TMO = 256;
  logic clk = 1'b0, reset = 1'b1;
  logic obi_req = 1'b0, obi_reqpar = 1'b1, obi_gnt, obi_gntpar;
  logic [31:0] obi_addr = '0;
  logic obi_we = 1'b0;
  logic [DW/8-1:0] obi_be = '0;
  logic [DW-1:0] obi_wdata = '0;
  logic [IDW-1:0] obi_aid = '0;
  logic obi_rvalid, obi_rvalidpar;
  logic obi_rready = 1'b0, obi_rreadypar = 1'b1;
  logic [DW-1:0] obi_rdata;
  logic obi_err;
  logic [IDW-1:0] obi_rid;
  logic [31:0] apb_paddr;
  logic [DW-1:0] apb_pwdata;
  logic apb_pwrite, apb_penable;
  logic [DW/8-1:0] apb_pstrb;
  logic [N-1:0] apb_psel;
  logic [N*DW-1:0] apb_prdata = '0;
  logic [N-1:0] apb_pready = '0, apb_pslverr = '0;
  logic [7:0] ss_ctrl_icn = 8'h03;
  always #5 clk = ~clk;
  obi_apb_splitter #(
    .NUM_TARGETS(N), .OBI_AW(32), .OBI_DW(DW), .OBI_IDW(IDW), .APB_AW(32),
    .ADDR_BASE(BASE), .SS_SIZE(SS), .TIMEOUT_CYCLES(TMO), .SS_CTRL_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .obi_req(obi_req), .obi_reqpar(obi_reqpar), .obi_gnt(obi_gnt), .obi_gntpar(obi_gntpar),
    .obi_addr(obi_addr), .obi_we(obi_we), .obi_be(obi_be), .obi_wdata(obi_wdata), .obi_aid(obi_aid),
    .obi_rvalid(obi_rvalid), .obi_rvalidpar(obi_rvalidpar), .obi_rready(obi_rready), .obi_rreadypar(obi_rreadypar),
    .obi_rdata(obi_rdata), .obi_err(obi_err), .obi_rid(obi_rid),
    .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata), .apb_pwrite(apb_pwrite), .apb_pstrb(apb_pstrb),
    .apb_penable(apb_penable), .apb_psel(apb_psel), .apb_prdata(apb_prdata), .apb_pready(apb_pready),
    .apb_pslverr(apb_pslverr), .ss_ctrl_icn(ss_ctrl_icn)
  );
  typedef struct {
    logic [31:0] rdata;
    logic err;
    logic [IDW-1:0] rid;
    int t0;
    int lat;
  } exp_t;
  exp_t exp_q[$];
  int vectors = 0, fails = 0, cyc = 0;
  bit cur_mapped = 0, cur_hang = 0, cur_slverr = 0, cur_we = 0;
  int cur_tgt = 0, cur_waits = 0;
  logic [31:0] cur_addr = '0, cur_wdata = '0, cur_rdata = '0;
  logic [3:0] cur_be = '0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask
  task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be, input logic [31:0] wdata,
                       input logic [IDW-1:0] aid, input int waits, input logic slverr, input logic [31:0] rdata, input bit hang);
    longint off;
    bit mapped, granted;
    exp_t e;
    granted = 0;
    @(negedge clk);
    #2;
    obi_req = 1; obi_reqpar = 0;
    obi_addr = addr; obi_we = we; obi_be = be; obi_wdata = wdata; obi_aid = aid;
    for (int k = 0; k < 1000 && !granted; k++) begin
      #1;
      if (obi_gnt) granted = 1;
      else begin
        @(negedge clk);
        #2;
      end
    end
    if (!granted) begin
      vectors++; fails++;
      $display("FAIL gnt_timeout: no grant for addr %0h", addr);
      obi_req = 0; obi_reqpar = 1;
      return;
    end
    off = longint'(addr) - longint'(BASE);
    mapped = off >= 0 && off / SS < N;
    cur_mapped = mapped; cur_tgt = mapped ? int'(off / SS) : 0;
    cur_hang = hang; cur_waits = waits; cur_slverr = slverr; cur_rdata = rdata;
    cur_addr = addr; cur_we = we; cur_be = be; cur_wdata = wdata;
    e.rid = aid;
    e.t0 = cyc;
    if (!mapped) begin
      e.rdata = 0; e.err = ss_ctrl_icn[1]; e.lat = 1;
    end else if (hang) begin
      e.rdata = 0; e.err = 1; e.lat = 2 + TMO;
    end else begin
      e.rdata = we ? 32'h0 : rdata; e.err = slverr; e.lat = 3 + waits;
    end
    if (!(mapped && hang && !ss_ctrl_icn[0])) exp_q.push_back(e);
    @(posedge clk);
    #1;
    obi_req = 0; obi_reqpar = 1;
  endtask
  task automatic wait_idle();
    bit done;
    done = 0;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      done = exp_q.size() == 0 && !obi_rvalid;
    end
    if (!done) begin
      vectors++; fails++;
      $display("FAIL idle_timeout: %0d responses outstanding", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic set_ctrl(input logic [7:0] c);
    wait_idle();
    #2;
    ss_ctrl_icn = c;
  endtask
  task automatic rand_txn();
    logic [31:0] a;
    int t;
    if ($urandom % 6 == 0)
      case ($urandom % 4)
        0: a = BASE - 4;
        1: a = BASE + N * SS + ($urandom % SS & ~3);
        2: a = $urandom | 32'h8000_0000;
        default: a = 32'h0000_0100;
      endcase
    else begin
      t = $urandom % N;
      a = BASE + t * SS + (($urandom % 4 == 0) ? SS - 4 : ($urandom % SS & ~3));
    end
    issue(a, 1'($urandom), 4'($urandom), $urandom, IDW'($urandom), $urandom % 5, $urandom % 4 == 0, $urandom, 0);
  endtask
  // APB target model: the expected target answers after its wait count, all others babble
  int acc = 0;
  always @(negedge clk) begin
    acc = (apb_psel != 0 && apb_penable) ? acc + 1 : 0;
    for (int i = 0; i < N; i++) begin
      apb_pready[i] = 1'($urandom);
      apb_pslverr[i] = 1'($urandom);
      apb_prdata[i*DW +: DW] = $urandom;
    end
    if (cur_mapped) begin
      apb_prdata[cur_tgt*DW +: DW] = cur_rdata;
      apb_pready[cur_tgt] = !cur_hang && acc == cur_waits + 1;
      apb_pslverr[cur_tgt] = apb_pready[cur_tgt] ? cur_slverr : 1'($urandom);
    end
  end
  logic [N-1:0] prev_psel = '0;
  always @(negedge clk) begin
    logic [N-1:0] oh;
    if (!reset) begin
      if (apb_psel != 0) begin
        oh = '0;
        if (cur_mapped) oh[cur_tgt] = 1'b1;
        chk("psel", apb_psel, oh);
        chk("paddr", apb_paddr, cur_addr);
        chk("pwrite", apb_pwrite, cur_we);
        chk("pstrb", apb_pstrb, cur_we ? cur_be : 4'h0);
        chk("pwdata", apb_pwdata, cur_wdata);
        chk("penable", apb_penable, prev_psel != 0);
      end else chk("penable_idle", apb_penable, 0);
    end
    prev_psel = apb_psel;
  end
  bit in_resp = 0;
  int hold = 0;
  exp_t ce;
  logic [31:0] s_rdata;
  logic s_err;
  logic [IDW-1:0] s_rid;
  always @(negedge clk) begin
    if (obi_rvalid === 1'b1) begin
      chk("psel_in_resp", apb_psel, 0);
      if (obi_req) chk("gnt_in_resp", obi_gnt, 0);
      if (!in_resp) begin
        in_resp = 1;
        s_rdata = obi_rdata; s_err = obi_err; s_rid = obi_rid;
        if (exp_q.size() == 0) begin
          vectors++; fails++;
          $display("FAIL unexpected_rvalid: rdata %0h err %0b", obi_rdata, obi_err);
        end else begin
          ce = exp_q.pop_front();
          chk("rdata", obi_rdata, ce.rdata);
          chk("err", obi_err, ce.err);
          chk("rid", obi_rid, ce.rid);
          chk("latency", cyc - ce.t0, ce.lat);
        end
        hold = ($urandom % 3 == 0) ? $urandom_range(1, 5) : 0;
      end else begin
        chk("rdata_stable", obi_rdata, s_rdata);
        chk("err_stable", obi_err, s_err);
        chk("rid_stable", obi_rid, s_rid);
      end
      obi_rready = hold == 0;
      if (hold > 0) hold--;
    end else begin
      in_resp = 0;
      obi_rready = 1'($urandom);
    end
    obi_rreadypar = ~obi_rready;
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_gnt", {obi_gnt, obi_gntpar}, 2'b01);
    chk("rst_rvalid", {obi_rvalid, obi_rvalidpar}, 2'b01);
    chk("rst_resp", {obi_rdata, obi_err, obi_rid}, 0);
    chk("rst_apb_ctl", {apb_psel, apb_penable, apb_pwrite, apb_pstrb}, 0);
    chk("rst_apb_data", {apb_paddr, apb_pwdata}, 0);
    #2 reset = 0;
    issue(32'h0105_2004, 0, 4'hf, 32'h0, 1, 0, 0, 32'hCAFE_0002, 0);
    issue(32'h0105_4010, 1, 4'b0011, 32'h1234_5678, 0, 3, 0, 32'hDEAD_BEEF, 0);
    issue(32'h0105_1000, 0, 4'hf, 32'h0, 1, 1, 1, 32'h5A5A_0001, 0);
    issue(32'h0105_5000, 0, 4'hf, 32'h0, 0, 0, 0, 32'h0, 0);
    set_ctrl(8'h00);
    issue(32'h0105_5000, 0, 4'hf, 32'h0, 1, 0, 0, 32'h0, 0);
    set_ctrl(8'h01);
    issue(32'h0105_0020, 0, 4'hf, 32'h0, 1, 0, 0, 32'h1111_2222, 1);
    set_ctrl(8'h00);
    issue(32'h0105_0008, 1, 4'hf, 32'hAAAA_5555, 0, 0, 0, 32'h0, 1);
    repeat (300) @(negedge clk);
    chk("hang_rvalid", obi_rvalid, 0);
    chk("hang_access", {apb_psel, apb_penable}, 6'b00001_1);
    #2 reset = 1;
    @(negedge clk);
    chk("rst_mid_access", {apb_psel, apb_penable, obi_rvalid}, 0);
    #2 reset = 0;
    issue(32'h0105_3ffc, 0, 4'hf, 32'h0, 1, 2, 0, 32'h0BAD_F00D, 0);
    set_ctrl(8'hA7);
    for (int i = 0; i < 200; i++) rand_txn();
    set_ctrl(8'h5C);
    for (int i = 0; i < 100; i++) rand_txn();
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
